z8_prog_loader: RTL

Byte-stream program loader for the z8 processor core: receives a framed instruction image over a valid/ready byte interface and writes it word-by-word into core program memory starting at address 0. Sits between a host link (UART/debug bridge) and the program-memory write port. Holds the core in reset until a complete image with a correct checksum has been committed, then releases it.

---
 rtl/z8_loader_pkg.sv | 8 +
 rtl/z8_prog_loader_if.sv | 14 +
 rtl/z8_word_assembler.sv | 40 ++++
 rtl/z8_prog_loader.sv | 83 ++++++++
 4 files changed

// File: rtl/z8_loader_pkg.sv
// z8_loader_pkg: shared loader states, framing constants and word-size helper
package z8_loader_pkg;
  typedef enum logic [2:0] {IDLE, COUNT, DATA, CHECK, DONE, ERROR} state_t;
  localparam logic [7:0] SYNC_BYTE = 8'hA5;
  function automatic int bytes_per_word(int instr_w);
    return (instr_w + 7) / 8;
  endfunction
endpackage

// File: rtl/z8_prog_loader_if.sv
// z8_prog_loader_if: host byte stream plus program-memory write port
interface z8_prog_loader_if #(
  parameter int ADDR_W  = 8,
  parameter int INSTR_W = 40
);
  logic               in_valid;
  logic [7:0]         in_data;
  logic               in_ready;
  logic               pm_we;
  logic [ADDR_W-1:0]  pm_addr;
  logic [INSTR_W-1:0] pm_wdata;
  modport master(output in_valid, in_data, input in_ready, pm_we, pm_addr, pm_wdata);
  modport slave(input in_valid, in_data, output in_ready, pm_we, pm_addr, pm_wdata);
endinterface

// File: rtl/z8_word_assembler.sv
// z8_word_assembler: packs big-endian bytes into instruction words, one-cycle word_valid pulse
module z8_word_assembler
  import z8_loader_pkg::*;
#(
  parameter int INSTR_W = 40
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               clr,
  input  logic               en,
  input  logic [7:0]         din,
  output logic               last,
  output logic               word_valid,
  output logic [INSTR_W-1:0] word
);
  localparam int BPW = bytes_per_word(INSTR_W);
  localparam int CW  = BPW > 1 ? $clog2(BPW) : 1;
  logic [CW-1:0]      cnt;
  logic [8*BPW-9:0]   sh;
  logic [8*BPW-1:0]   full;
  assign full = {sh, din};
  assign last = cnt == CW'(BPW - 1);
  // word holds its value between completions so pm_wdata stays stable
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      cnt        <= '0;
      sh         <= '0;
      word       <= '0;
      word_valid <= 1'b0;
    end else begin
      word_valid <= en & last;
      if (clr) cnt <= '0;
      else if (en) begin
        cnt <= last ? '0 : cnt + 1'b1;
        sh  <= full[8*BPW-9:0];
        if (last) word <= full[INSTR_W-1:0];
      end
    end
  end
endmodule

// File: rtl/z8_prog_loader.sv
// z8_prog_loader: framed byte-stream program loader; holds the z8 core in reset until a
// checksum-verified image has been written to program memory from address 0
module z8_prog_loader
  import z8_loader_pkg::*;
#(
  parameter int OPCODE_W  = 8,
  parameter int OPERAND_W = 16,
  parameter int ADDR_W    = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  z8_prog_loader_if.slave  bus,
  output logic             core_reset,
  output logic             busy,
  output logic             done,
  output logic             err
);
  localparam int INSTR_W = OPCODE_W + 2 * OPERAND_W;
  localparam int DEPTH   = 2 ** ADDR_W;
  state_t             state, nxt;
  logic               acc, en, last, word_valid, bad_n;
  logic [7:0]         left, chk;
  logic [ADDR_W-1:0]  widx, addr;
  logic [INSTR_W-1:0] word;
  assign bus.in_ready = state != DONE && state != ERROR;
  assign acc          = bus.in_valid & bus.in_ready;
  assign en           = acc && state == DATA;
  assign bad_n        = bus.in_data == 8'd0 || int'(bus.in_data) > DEPTH;
  assign busy         = state inside {COUNT, DATA, CHECK};
  assign done         = state == DONE;
  assign err          = state == ERROR;
  assign bus.pm_we    = word_valid;
  assign bus.pm_addr  = addr;
  assign bus.pm_wdata = word;
  z8_word_assembler #(.INSTR_W(INSTR_W)) u_asm (
    .clk        (clk),
    .reset      (reset),
    .clr        (state == COUNT),
    .en         (en),
    .din        (bus.in_data),
    .last       (last),
    .word_valid (word_valid),
    .word       (word)
  );
  always_comb begin
    nxt = state;
    case (state)
      IDLE:    nxt = (acc && bus.in_data == SYNC_BYTE) ? COUNT : IDLE;
      COUNT:   nxt = acc ? (bad_n ? ERROR : DATA) : COUNT;
      DATA:    nxt = (en && last && left == 8'd1) ? CHECK : DATA;
      CHECK:   nxt = acc ? (bus.in_data == chk ? DONE : ERROR) : CHECK;
      default: nxt = start ? IDLE : state;
    endcase
  end
  // core_reset follows the next state so it changes on the same edge as the FSM
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state      <= IDLE;
      left       <= '0;
      chk        <= '0;
      widx       <= '0;
      addr       <= '0;
      core_reset <= 1'b1;
    end else begin
      state      <= nxt;
      core_reset <= nxt != DONE;
      if (acc && state == COUNT) begin
        left <= bus.in_data;
        chk  <= '0;
        widx <= '0;
      end
      if (en) begin
        chk <= chk ^ bus.in_data;
        if (last) begin
          left <= left - 8'd1;
          widx <= widx + 1'b1;
          addr <= widx;
        end
      end
    end
  end
endmodule
